// File: rtl/evm_pkg.sv
// evm_pkg: shared voting-datapath constants, state type and one-hot decode.
package evm_pkg;
  localparam int NUM_CANDIDATES = 4;
  localparam int CAND_W = 2;
  localparam int VOTER_W = 3;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_CONFIRM, S_COMMIT, S_HOLD} state_t;
  function automatic logic [CAND_W-1:0] onehot_to_index(input logic [NUM_CANDIDATES-1:0] oh);
    logic [CAND_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++)
      if (oh[i]) idx = CAND_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/button_sync_edge.sv
// button_sync_edge: multi-stage synchroniser plus rising-edge detector for raw buttons.
module button_sync_edge #(
  parameter int W = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] rise
);
  localparam int SW = $clog2(STAGES + 1);
  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] prev_q, armed_q;
  logic [SW-1:0] settle_q;
  logic settled;
  assign settled = settle_q == SW'(STAGES);
  // a bit only arms once seen low after the chain has filled, so buttons held through reset never edge
  assign rise = sync_q[STAGES-1] & ~prev_q & armed_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      armed_q <= '0;
      settle_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
      armed_q <= armed_q | ({W{settled}} & ~sync_q[STAGES-1]);
      settle_q <= settled ? settle_q : settle_q + 1'b1;
    end
endmodule

// File: rtl/ballot_entry_controller.sv
// ballot_entry_controller: turns voter-ID strobe and raw buttons into one clean vote command.
module ballot_entry_controller
  import evm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [VOTER_W-1:0]        voter_id,
  input  logic [NUM_CANDIDATES-1:0] cand_btn,
  input  logic                      confirm_btn,
  input  logic                      cancel_btn,
  output logic [CAND_W-1:0]         candidate_number,
  output logic [VOTER_W-1:0]        voter_number,
  output logic                      vote_signal,
  output logic                      ready,
  output logic                      sel_valid,
  output logic                      err_pulse,
  output logic                      timeout_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [CAND_W-1:0] cand_n;
  logic [VOTER_W-1:0] voter_n;
  logic err_n, to_n, multi, single;
  logic [NUM_CANDIDATES+1:0] btn_rise;
  logic [NUM_CANDIDATES-1:0] cand_e;
  logic confirm_e, cancel_e;
  button_sync_edge #(.W(NUM_CANDIDATES + 2), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  ({cancel_btn, confirm_btn, cand_btn}),
    .rise (btn_rise)
  );
  assign {cancel_e, confirm_e, cand_e} = btn_rise;
  assign multi = (cand_e & (cand_e - 1'b1)) != '0;
  assign single = |cand_e && !multi;
  always_comb begin
    state_n = state;
    timer_n = timer;
    hold_n = hold_cnt;
    cand_n = candidate_number;
    voter_n = voter_number;
    err_n = id_valid && state != S_IDLE;
    to_n = 1'b0;
    case (state)
      S_IDLE:
        if (id_valid) begin
          state_n = S_SELECT;
          voter_n = voter_id;
          timer_n = '0;
        end
      S_SELECT, S_CONFIRM: begin
        timer_n = timer + 1'b1;
        err_n = err_n || multi;
        if (cancel_e) state_n = S_IDLE;
        else if (timer == T_LAST) begin
          state_n = S_IDLE;
          to_n = 1'b1;
        end else if (confirm_e && state == S_CONFIRM) state_n = S_COMMIT;
        else if (single) begin
          state_n = S_CONFIRM;
          cand_n = onehot_to_index(cand_e);
          timer_n = '0;
        end
      end
      S_COMMIT: begin
        state_n = S_HOLD;
        hold_n = '0;
      end
      S_HOLD: begin
        hold_n = hold_cnt + 1'b1;
        state_n = hold_cnt == H_LAST ? S_IDLE : S_HOLD;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
      hold_cnt <= '0;
      candidate_number <= '0;
      voter_number <= '0;
      vote_signal <= 1'b0;
      ready <= 1'b1;
      sel_valid <= 1'b0;
      err_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      hold_cnt <= hold_n;
      candidate_number <= cand_n;
      voter_number <= voter_n;
      vote_signal <= state_n == S_COMMIT;
      ready <= state_n == S_IDLE;
      sel_valid <= state_n == S_CONFIRM;
      err_pulse <= err_n;
      timeout_pulse <= to_n;
    end
endmodule
